// File: rtl/note_pan_encoder.sv
// note_pan_encoder: tags three voice samples with a per-voice pan bit that is fixed,
// alternating or LFSR-random, hopping every HOP_SAMPLES audio strobes.
module note_pan_encoder #(
    parameter int          HOP_SAMPLES = 12000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        sample_valid,
    input  logic [15:0] sample_a,
    input  logic [15:0] sample_b,
    input  logic [15:0] sample_c,
    input  logic [2:0]  voice_en,
    input  logic [1:0]  mode_a,
    input  logic [1:0]  mode_b,
    input  logic [1:0]  mode_c,
    input  logic        hop_sync,
    output logic [16:0] note_data_a,
    output logic [16:0] note_data_b,
    output logic [16:0] note_data_c,
    output logic        note_valid,
    output logic        hop
);
    localparam int CW = HOP_SAMPLES > 1 ? $clog2(HOP_SAMPLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOP_SAMPLES - 1);

    logic [CW-1:0] count;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_adv;
    logic          pan_a, pan_b, pan_c;
    logic          pan_a_nx, pan_b_nx, pan_c_nx;
    logic          hop_now;

    // mode[1] selects hopping behaviour; fixed modes simply drive mode[0]
    function automatic logic pan_next(input logic [1:0] mode, input logic pan,
                                      input logic hopping, input logic rnd);
        return mode[1] ? (hopping ? (mode[0] ? rnd : ~pan) : pan) : mode[0];
    endfunction

    always_comb begin
        hop_now  = sample_valid && !hop_sync && (count == LAST);
        lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        pan_a_nx = pan_next(mode_a, pan_a, hop_now, lfsr_adv[0]);
        pan_b_nx = pan_next(mode_b, pan_b, hop_now, lfsr_adv[1]);
        pan_c_nx = pan_next(mode_c, pan_c, hop_now, lfsr_adv[2]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count       <= '0;
            lfsr        <= LFSR_SEED;
            pan_a       <= 1'b1;
            pan_b       <= 1'b0;
            pan_c       <= 1'b1;
            note_data_a <= '0;
            note_data_b <= '0;
            note_data_c <= '0;
            note_valid  <= 1'b0;
            hop         <= 1'b0;
        end else begin
            if (hop_sync)
                count <= '0;
            else if (sample_valid)
                count <= hop_now ? '0 : count + 1'b1;
            if (hop_now)
                lfsr <= lfsr_adv;
            note_valid <= sample_valid;
            hop        <= hop_now;
            if (sample_valid) begin
                pan_a       <= pan_a_nx;
                pan_b       <= pan_b_nx;
                pan_c       <= pan_c_nx;
                note_data_a <= {voice_en[0] ? sample_a : 16'd0, pan_a_nx};
                note_data_b <= {voice_en[1] ? sample_b : 16'd0, pan_b_nx};
                note_data_c <= {voice_en[2] ? sample_c : 16'd0, pan_c_nx};
            end
        end
    end
endmodule
